interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Sequences exception entry and exit for the multi-cycle MIPS core.
- Latches a non-maskable interrupt (edge) and prioritised maskable requests (level).
- Waits for an instruction boundary (CPU_busy low), then captures the EPC and cause, and pulses a PC redirect to the handler vector.
- Sits beside the control unit. It drives the PC-source override and holds the EPC used by eret.

Parameters:
- NUM_IRQ, 4, number of maskable request lines (≥2); IDW = $clog2(NUM_IRQ)
- NMI_VECTOR, 32'h0000_0180, handler address for NMI
- IRQ_BASE, 32'h0000_0200, handler address for IRQ 0
- IRQ_STRIDE, 32'h0000_0020, address spacing between IRQ handlers

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- NON_maskable_interrupt  in  1  NMI request, rising-edge sensitive
- interrupt_r  in  NUM_IRQ  maskable requests, level, bit 0 highest priority
- CPU_busy  in  1  high while an instruction is mid-execution; low at a fetch boundary
- current_pc  in  32  architectural PC (pc_out)
- eret  in  1  one-cycle pulse from control unit: return from handler
- ie_we  in  1  write global interrupt enable
- ie_wdata  in  1  new global enable value
- mask_we  in  1  write mask register
- mask_wdata  in  NUM_IRQ  new mask (1 = masked)
- take_int  out  1  one-cycle pulse: load PC from vector_pc
- vector_pc  out  32  handler address, valid while take_int high
- epc  out  32  saved return PC
- cause  out  1+IDW  {is_nmi, irq_id}
- ack  out  NUM_IRQ  one-hot pulse coincident with take_int (IRQ only)
- in_service  out  1  handler running
- ie  out  1  global enable
- irq_mask  out  NUM_IRQ  current mask

Behaviour:
- Reset:
  - state IDLE; take_int=0, ack=0, in_service=0, ie=0
  - irq_mask all ones; epc=0, cause=0, vector_pc=0
  - nmi_pending=0; NMI edge-detect register cleared
- NMI detect: nmi_prev registered each cycle. A rising edge sets nmi_pending, which stays set until the NMI is dispatched. Edges while nmi_pending is already 1 are absorbed (no count).
- Qualified IRQ: irq_q = interrupt_r & ~irq_mask, gated by ie. pend = nmi_pending | (ie & |irq_q).
- Priority: NMI > interrupt_r[0] > … > interrupt_r[NUM_IRQ-1]. The winner is chosen in the boundary cycle, not at request time.
- States:
  - IDLE: if pend and !in_service → WAIT.
  - WAIT:
    - if !pend → IDLE (request withdrawn, no side effects).
    - else if CPU_busy==0 → DISPATCH. On this edge: epc←current_pc, cause←winner, vector_pc←NMI_VECTOR or IRQ_BASE+id*IRQ_STRIDE, saved_ie←ie.
    - else stay in WAIT.
  - DISPATCH (exactly 1 cycle): take_int=1; ack[id]=1 for IRQ.
    - Next edge: in_service←1, ie←0, nmi_pending←0 if the winner was NMI → SERVICE.
  - SERVICE: on eret → IDLE, with in_service←0 and ie←saved_ie. Otherwise stay.
    - New NMI edges latch into nmi_pending and are taken after eret; there is no nesting.
- Latency: request seen in IDLE at cycle N with CPU_busy low throughout → WAIT at N+1 → take_int high in cycle N+2.
- Register writes:
  - ie_we and mask_we take effect on the next edge, in any state.
  - An ie_we on the same edge as the DISPATCH→SERVICE transition is overridden (ie←0).
  - An ie_we on the same edge as eret: ie_wdata wins.
- eret outside SERVICE is ignored.
- An NMI edge in the same cycle as eret is latched and dispatched normally afterwards.
- Reset mid-operation, including during DISPATCH: returns to the reset state at the next edge; no take_int is issued after reset assertion.
- ack and take_int are never high outside DISPATCH.

Test Plan:
- ie=1, mask=4'b0000, interrupt_r=4'b0110, CPU_busy=0, current_pc=32'h40 → take_int 2 cycles later, vector_pc=32'h220, cause={0,1}, ack=4'b0010, epc=32'h40, ie=0.
- NMI rising edge while ie=0 and interrupt_r=4'b0001 unmasked; CPU_busy held high 3 cycles → no take_int until CPU_busy falls. Then vector_pc=32'h180, cause={1,0}, ack=0.
- In SERVICE, raise interrupt_r[0] and pulse eret with saved_ie=1 → in_service drops, ie=1, second dispatch to 32'h200 follows.
- interrupt_r[2] asserted then dropped while CPU_busy=1 → WAIT returns to IDLE; take_int never asserts; epc unchanged.
- Mask bit 3 via mask_we, assert interrupt_r[3] → no dispatch. Unmask → dispatch to 32'h260.
- Assert reset during DISPATCH → take_int low next cycle, in_service=0, irq_mask=4'b1111, ie=0.

Source files
------------

// File: rtl/interrupt_controller.sv
// Exception sequencer for the multi-cycle MIPS core.
// Latches NMI edges and prioritised maskable requests, waits for an instruction
// boundary, captures EPC/cause, and pulses a PC redirect to the handler vector.
module interrupt_controller #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] NMI_VECTOR = 32'h0000_0180,
  parameter logic [31:0] IRQ_BASE   = 32'h0000_0200,
  parameter logic [31:0] IRQ_STRIDE = 32'h0000_0020,
  localparam int unsigned IDW       = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               NON_maskable_interrupt,
  input  logic [NUM_IRQ-1:0] interrupt_r,
  input  logic               CPU_busy,
  input  logic [31:0]        current_pc,
  input  logic               eret,
  input  logic               ie_we,
  input  logic               ie_wdata,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               take_int,
  output logic [31:0]        vector_pc,
  output logic [31:0]        epc,
  output logic [IDW:0]       cause,
  output logic [NUM_IRQ-1:0] ack,
  output logic               in_service,
  output logic               ie,
  output logic [NUM_IRQ-1:0] irq_mask
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISPATCH,
    ST_SERVICE
  } state_e;

  state_e             state_q, state_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_pending_q, nmi_pending_d;
  logic               ie_q, ie_d;
  logic               saved_ie_q, saved_ie_d;
  logic               in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        vector_q, vector_d;
  logic [IDW:0]       cause_q, cause_d;

  logic               nmi_edge;
  logic [NUM_IRQ-1:0] irq_qual;
  logic               pend;
  logic [IDW-1:0]     win_id;

  // Request qualification and fixed-priority selection (lowest index wins).
  always_comb begin
    nmi_edge = NON_maskable_interrupt & ~nmi_prev_q;
    irq_qual = ie_q ? (interrupt_r & ~mask_q) : '0;
    pend     = nmi_pending_q | (|irq_qual);
    win_id   = '0;
    // Scan from the lowest priority upward so the last hit is the highest priority.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_qual[i]) win_id = IDW'(i);
    end
  end

  // Next-state logic for the sequencer and its architectural registers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    nmi_prev_d    = NON_maskable_interrupt;
    nmi_pending_d = nmi_pending_q | nmi_edge;
    ie_d          = ie_we ? ie_wdata : ie_q;
    saved_ie_d    = saved_ie_q;
    in_service_d  = in_service_q;
    mask_d        = mask_we ? mask_wdata : mask_q;
    epc_d         = epc_q;
    vector_d      = vector_q;
    cause_d       = cause_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend && !in_service_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!pend) begin
          state_d = ST_IDLE;
        end else if (!CPU_busy) begin
          state_d    = ST_DISPATCH;
          epc_d      = current_pc;
          saved_ie_d = ie_q;
          if (nmi_pending_q) begin
            cause_d  = {1'b1, {IDW{1'b0}}};
            vector_d = NMI_VECTOR;
          end else begin
            cause_d  = {1'b0, win_id};
            vector_d = IRQ_BASE + 32'(win_id) * IRQ_STRIDE;
          end
        end
      end
      ST_DISPATCH: begin
        state_d      = ST_SERVICE;
        in_service_d = 1'b1;
        ie_d         = 1'b0;
        // A dispatched NMI consumes the pending flag, including any edge seen meanwhile.
        if (cause_q[IDW]) nmi_pending_d = 1'b0;
      end
      ST_SERVICE: begin
        if (eret) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
          ie_d         = ie_we ? ie_wdata : saved_ie_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q       <= ST_IDLE;
      nmi_prev_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
      ie_q          <= 1'b0;
      saved_ie_q    <= 1'b0;
      in_service_q  <= 1'b0;
      mask_q        <= '1;
      epc_q         <= '0;
      vector_q      <= '0;
      cause_q       <= '0;
    end else begin
      state_q       <= state_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
      ie_q          <= ie_d;
      saved_ie_q    <= saved_ie_d;
      in_service_q  <= in_service_d;
      mask_q        <= mask_d;
      epc_q         <= epc_d;
      vector_q      <= vector_d;
      cause_q       <= cause_d;
    end
  end

  // Redirect pulse and acknowledge exist only during the single DISPATCH cycle.
  always_comb begin
    take_int = (state_q == ST_DISPATCH);
    ack      = '0;
    if (take_int && !cause_q[IDW]) ack[cause_q[IDW-1:0]] = 1'b1;
  end

  assign vector_pc  = vector_q;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign in_service = in_service_q;
  assign ie         = ie_q;
  assign irq_mask   = mask_q;

endmodule
